seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Serial pattern transmitter; the stimulus side of the team's serial sequence detectors.
- Accepts a parallel DATA_W-bit word over a valid/ready handshake and shifts it out MSB-first on a 1-bit serial line `x`, one bit per clock.
- Each word is followed by a fixed idle gap of zeros.
- Drives the `x` input of a detector (e.g. for target 1101) in lab benches and on-board demos.

Parameters:
- DATA_W, 4: width of the parallel word, in serial bits per frame; legal range 2..16.
- GAP_CYC, 2: number of forced-zero idle cycles after each frame; legal range 0..15.
- CNT_W, 8: width of the frames-sent counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- data  input  DATA_W  word to transmit; sampled only on accept.
- valid  input  1  `data` is valid.
- ready  output  1  block can accept a word; combinational, equals (state == IDLE).
- x  output  1  serial bit stream; registered.
- busy  output  1  frame in progress (SHIFT or GAP); registered.
- done  output  1  one-cycle pulse at end of frame; registered.
- frame_cnt  output  CNT_W  number of completed frames.

Behaviour:
- Reset (rst = 0, asynchronous, any time, including mid-frame):
  - state = IDLE; x = 0, busy = 0, done = 0, frame_cnt = 0.
  - Shift register and bit/gap counters cleared.
  - An interrupted frame is abandoned; no done pulse is produced for it.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - ready = 1, x = 0.
  - Accept occurs when valid & ready at a clock edge (cycle T):
    - x <= data[DATA_W-1]; shift register <= data shifted left by 1.
    - bit_cnt <= DATA_W-1; busy <= 1; state -> SHIFT.
  - valid low: remain in IDLE; `data` is ignored.
- SHIFT:
  - x holds the current bit.
  - While bit_cnt != 0 (each edge): x <= shreg MSB; shreg <<= 1; bit_cnt decrements.
  - Bit i (i = 0 is the MSB) is on x during cycle T+1+i.
  - When bit_cnt == 0:
    - If GAP_CYC > 0: x <= 0, gap_cnt <= GAP_CYC-1, state -> GAP.
    - If GAP_CYC == 0: go to frame end.
- GAP:
  - x = 0.
  - gap_cnt decrements each edge; at gap_cnt == 0 go to frame end.
- Frame end (single edge):
  - state -> IDLE; busy <= 0; done <= 1 for one cycle; x <= 0.
  - frame_cnt increments, wrapping modulo 2^CNT_W without saturating.
- Timing and throughput:
  - ready is high again in cycle T+DATA_W+GAP_CYC+1, coincident with done.
  - If valid is held high in that cycle, the next word is accepted there.
  - Maximum throughput is one word per DATA_W+GAP_CYC+1 cycles.
  - `data` changes while not ready have no effect.
- Simultaneous events: done pulse and a new accept in the same cycle are legal. At that edge:
  - done clears.
  - A new frame starts (x <= MSB of the new word).
  - frame_cnt is unaffected by the accept.

Optional Feature:
- Macro: SEQ_PATTERN_TX_PARITY_EN.
- Defined:
  - After the last data bit, one extra SHIFT cycle drives the even-parity bit (XOR of all DATA_W bits) on x, before GAP.
  - Frame length becomes DATA_W+1 bit cycles.
  - ready returns at T+DATA_W+GAP_CYC+2.
- Undefined: no parity bit; timing exactly as in Behaviour.

Decomposition:
- Package seq_pattern_pkg:
  - State enum typedef (IDLE, SHIFT, GAP) and its 2-bit encoding.
  - Default DATA_W/GAP_CYC localparams.
  - Constant TARGET_1101 = 4'b1101, shared with the detector benches.
- One natural sub-module, seq_shift_out:
  - Load-able MSB-first shift register with down-counter and last-bit flag.
  - The top FSM handles handshake, gap, done and the counter.

Test Plan:
1. Reset, then accept data = 4'b1101 at T with GAP_CYC = 2:
   - x = 1,1,0,1 in cycles T+1..T+4, then 0,0 in T+5..T+6.
   - done = 1 and ready = 1 at T+7; frame_cnt = 1.
2. valid held high with data 1101 then 0110:
   - Second accept occurs in the done cycle (T+7).
   - x = 0,1,1,0 in T+8..T+11; no idle cycle between done and the new frame start.
3. Hold rst = 0 during cycle T+2 of a frame:
   - x = 0, busy = 0, ready = 1, frame_cnt = 0 immediately (asynchronous).
   - No done pulse after release.
4. GAP_CYC = 0, DATA_W = 4, back-to-back words 1101:
   - x sequence 1101 repeated with exactly one zero (IDLE/accept cycle) between frames.
   - A chained 1101 detector asserts z once per frame.
5. 256 frames with CNT_W = 8:
   - frame_cnt wraps 255 -> 0 on the 256th done.
6. With SEQ_PATTERN_TX_PARITY_EN, data = 4'b1101:
   - x = 1,1,0,1,1 (parity 1), then the gap.
   - done at T+8 with GAP_CYC = 2.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Optional build macro: SEQ_PATTERN_TX_PARITY_EN (adds an even-parity bit after each word).
package seq_pattern_pkg;

    // FSM states of the transmitter.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam int DEF_DATA_W  = 4;
    localparam int DEF_GAP_CYC = 2;
    localparam int DEF_CNT_W   = 8;

    // Pattern recognised by the companion sequence detectors.
    localparam logic [3:0] TARGET_1101 = 4'b1101;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Even parity over a zero-padded word of up to 16 bits.
    function automatic logic even_parity16(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/seq_shift_out.sv
// Loadable MSB-first shift register with a bit down-counter and last-bit flag.
// o_next_bit is the bit the caller should register onto the line this edge:
// the incoming MSB on load, otherwise the next stored bit.
module seq_shift_out #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_next_bit,
    output logic         o_last
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  r_shreg;
    logic [CW-1:0] r_bit_cnt;

    // Load drops the MSB (it goes straight to the line); shift advances one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_shreg   <= {i_data[W-2:0], 1'b0};
            r_bit_cnt <= CW'(W - 1);
        end else if (i_shift) begin
            r_shreg   <= {r_shreg[W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - CW'(1);
        end else begin
            r_shreg   <= r_shreg;
            r_bit_cnt <= r_bit_cnt;
        end
    end

    assign o_next_bit = i_load ? i_data[W-1] : r_shreg[W-1];
    assign o_last     = (r_bit_cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a parallel word on valid/ready and sends it
// MSB-first on x, followed by GAP_CYC forced-zero cycles and a one-cycle done pulse.
// Optional build macro: SEQ_PATTERN_TX_PARITY_EN (even-parity bit after the data bits).
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              x,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int SH_W = DATA_W + PAR_BITS;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_shift;
    logic             w_to_gap;
    logic             w_frame_end;
    logic             w_next_bit;
    logic             w_last;
    logic [SH_W-1:0]  w_load_word;
    logic [3:0]       r_gap_cnt;
    logic             r_x;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_frame_cnt;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    assign w_load_word = {data, even_parity16(16'(data))};
`else
    assign w_load_word = data;
`endif

    seq_shift_out #(.W(SH_W)) u_shift (
        .clk        (clk),
        .rst_n      (rst),
        .i_load     (w_accept),
        .i_shift    (w_shift),
        .i_data     (w_load_word),
        .o_next_bit (w_next_bit),
        .o_last     (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-edge control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_to_gap    = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (!w_last) begin
                    w_shift     = 1'b1;
                    w_state_nxt = SHIFT;
                end else if (GAP_CYC > 0) begin
                    w_to_gap    = 1'b1;
                    w_state_nxt = GAP;
                end else begin
                    w_frame_end = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GAP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered line, status, gap counter and frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gap_cnt   <= 4'd0;
            r_frame_cnt <= '0;
        end else begin
            r_done <= w_frame_end;

            if (w_accept || w_shift) begin
                r_x <= w_next_bit;
            end else begin
                r_x <= 1'b0;
            end

            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_frame_end) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end

            if (w_to_gap) begin
                r_gap_cnt <= 4'(GAP_CYC - 1);
            end else if ((r_state == GAP) && (r_gap_cnt != 4'd0)) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end else begin
                r_gap_cnt <= r_gap_cnt;
            end

            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    assign ready     = (r_state == IDLE);
    assign x         = r_x;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: table-driven frames on a GAP_CYC=2
// instance, plus reset-in-frame, back-to-back GAP_CYC=0 and counter-wrap sequences.
module tb_seq_pattern_tx;
    import seq_pattern_pkg::*;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int NB = 5;
    localparam int P0 = 6;
    localparam logic [5:0] PAT0 = 6'b110110;
`else
    localparam int NB = 4;
    localparam int P0 = 5;
    localparam logic [5:0] PAT0 = 6'b110100;
`endif
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data = 4'd0;
    logic       valid = 1'b0;
    logic       ready, x, busy, done;
    logic [7:0] frame_cnt;

    logic [3:0] data0 = 4'd0;
    logic       valid0 = 1'b0;
    logic       ready0, x0, busy0, done0;
    logic [7:0] frame_cnt0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] d;
        logic       chain;
        logic       par;
        logic [7:0] cnt;
    } vec_t;
    vec_t tbl[7];

    seq_pattern_tx #(.DATA_W(4), .GAP_CYC(GAP), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
        .x(x), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    seq_pattern_tx #(.DATA_W(4), .GAP_CYC(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .data(data0), .valid(valid0), .ready(ready0),
        .x(x0), .busy(busy0), .done(done0), .frame_cnt(frame_cnt0)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at the negedge of accept cycle T (valid/data already driven);
    // returns at the negedge of the done cycle.
    task automatic frame_check(input logic [3:0] d, input logic par, input logic chain,
                               input logic [3:0] nxt, input logic [7:0] exp_cnt);
        logic b;
        chk("accept_ready", 32'(ready), 32'd1);
        @(negedge clk);
        data  = chain ? nxt : ~d;
        valid = chain;
        for (int i = 0; i < NB; i++) begin
            b = (i < 4) ? d[3-i] : par;
            chk("shift_x", 32'(x), 32'(b));
            chk("shift_busy", 32'(busy), 32'd1);
            chk("shift_ready", 32'(ready), 32'd0);
            chk("shift_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        for (int g = 0; g < GAP; g++) begin
            chk("gap_x", 32'(x), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_ready", 32'(ready), 32'd0);
            @(negedge clk);
        end
        chk("end_done", 32'(done), 32'd1);
        chk("end_ready", 32'(ready), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_x", 32'(x), 32'd0);
        chk("end_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [3:0] win, ewin;
        logic [5:0] pat;
        logic [3:0] dk;
        logic       e;
        int         zc, ezc;
        logic       saw_done;

        tbl[0] = '{4'b1101, 1'b0, 1'b1, 8'd1};
        tbl[1] = '{4'b1101, 1'b1, 1'b1, 8'd2};
        tbl[2] = '{4'b0110, 1'b0, 1'b0, 8'd3};
        tbl[3] = '{4'b1000, 1'b0, 1'b1, 8'd4};
        tbl[4] = '{4'b0001, 1'b1, 1'b1, 8'd5};
        tbl[5] = '{4'b1111, 1'b0, 1'b0, 8'd6};
        tbl[6] = '{4'b0000, 1'b0, 1'b0, 8'd7};

        // Reset state
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven frames, including chained accept in the done cycle
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || !tbl[i-1].chain) begin
                data  = tbl[i].d;
                valid = 1'b1;
            end
            frame_check(tbl[i].d, tbl[i].par, tbl[i].chain,
                        (i < 6) ? tbl[i+1].d : 4'd0, tbl[i].cnt);
            if (!tbl[i].chain) begin
                @(negedge clk);
                chk("post_done_low", 32'(done), 32'd0);
                chk("post_x_idle", 32'(x), 32'd0);
                chk("post_ready", 32'(ready), 32'd1);
            end
        end

        // Asynchronous reset in the middle of a frame
        data  = 4'b1111;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("mid_x_before", 32'(x), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_x", 32'(x), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", 32'(saw_done), 32'd0);
        chk("mid_rst_idle", 32'(busy), 32'd0);

        // GAP_CYC = 0 back-to-back 1101 with a software 1101 detector on x
        chk("g0_ready", 32'(ready0), 32'd1);
        chk("g0_busy", 32'(busy0), 32'd0);
        data0  = TARGET_1101;
        valid0 = 1'b1;
        pat  = PAT0;
        win  = 4'd0;
        ewin = 4'd0;
        zc   = 0;
        ezc  = 0;
        for (int c = 0; c < 4 * P0; c++) begin
            @(negedge clk);
            e = pat[5 - (c % P0)];
            chk("g0_x", 32'(x0), 32'(e));
            win  = {win[2:0], x0};
            ewin = {ewin[2:0], e};
            if (win == TARGET_1101) zc++;
            if (ewin == TARGET_1101) ezc++;
        end
        valid0 = 1'b0;
        chk("g0_z_count", 32'(zc), 32'(ezc));
        chk("g0_done", 32'(done0), 32'd1);
        chk("g0_frame_cnt", 32'(frame_cnt0), 32'd4);
        @(negedge clk);

        // 256 frames: frame counter wraps 255 -> 0
        for (int k = 0; k < 256; k++) begin
            dk = 4'(k);
            if (k == 255) chk("wrap_pre", 32'(frame_cnt), 32'd255);
            data  = dk;
            valid = 1'b1;
            frame_check(dk, ^dk, 1'b0, 4'd0, 8'(k + 1));
            @(negedge clk);
        end
        chk("wrap_zero", 32'(frame_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
